// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: byte/half/word DMEM access with configurable wait states,
// plus memory-mapped LEDR/LEDG/HEX/LCD registers and a synchronised switch input.
module lsu_mc #(
  parameter int DMEM_AW = 11,
  parameter int MEM_LAT = 1,
  parameter int N_HEX   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_req,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_unsigned,
  input  logic        i_lsu_wren,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex [0:7],
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam logic [19:0] PG_LEDR  = 20'h10000;
  localparam logic [19:0] PG_LEDG  = 20'h10001;
  localparam logic [19:0] PG_HEXLO = 20'h10002;
  localparam logic [19:0] PG_HEXHI = 20'h10003;
  localparam logic [19:0] PG_LCD   = 20'h10004;
  localparam logic [19:0] PG_SW    = 20'h10010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        uns_q, wren_q, err_q;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        uns, wren;
  logic        accept, access, misalign, dmem_hit, mem_wr, io_wr;
  logic [31:0] rword, ld_val, be_data;
  logic [3:0]  be;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [6:0]  hex [0:7];
  logic [31:0] sw_meta, sw_sync;
  logic [31:0] mem [0:(2**DMEM_AW)-1];

  // In IDLE the access may complete on the accepting edge, so use the live request fields.
  always_comb begin
    if (state == S_IDLE) begin
      addr  = i_lsu_addr;
      wdata = i_st_data;
      size  = i_lsu_size;
      uns   = i_lsu_unsigned;
      wren  = i_lsu_wren;
    end else begin
      addr  = addr_q;
      wdata = wdata_q;
      size  = size_q;
      uns   = uns_q;
      wren  = wren_q;
    end
  end

  assign accept   = (state == S_IDLE) && i_lsu_req;
  assign misalign = (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign dmem_hit = (addr[31:DMEM_AW+2] == '0);
  assign mem_wr   = access && wren && !misalign && dmem_hit;
  assign io_wr    = access && wren && !misalign && !dmem_hit;

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (dmem_hit && !misalign && (MEM_LAT != 0)) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_DONE;
            access    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = S_DONE;
          access    = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rword = '0;
    if (dmem_hit) begin
      rword = mem[addr[DMEM_AW+1:2]];
    end else begin
      case (addr[31:12])
        PG_LEDR:  rword = o_io_ledr;
        PG_LEDG:  rword = o_io_ledg;
        PG_HEXLO: rword = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
        PG_HEXHI: rword = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};
        PG_LCD:   rword = o_io_lcd;
        PG_SW:    rword = sw_sync;
        default:  rword = '0;
      endcase
    end
  end

  always_comb begin
    case (addr[1:0])
      2'd0:    lane_b = rword[7:0];
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      default: lane_b = rword[31:24];
    endcase
    lane_h = addr[1] ? rword[31:16] : rword[15:0];
    case (size)
      2'b00:   ld_val = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   ld_val = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_val = rword;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick what lands.
  always_comb begin
    case (size)
      2'b00: begin
        be      = 4'b0001 << addr[1:0];
        be_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << {addr[1], 1'b0};
        be_data = {2{wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        be_data = wdata;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wren_q    <= 1'b0;
      err_q     <= 1'b0;
      o_ld_data <= '0;
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      for (int k = 0; k < 8; k++) hex[k] <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      state   <= state_nxt;
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
      if (accept) begin
        addr_q  <= i_lsu_addr;
        wdata_q <= i_st_data;
        size_q  <= i_lsu_size;
        uns_q   <= i_lsu_unsigned;
        wren_q  <= i_lsu_wren;
        cnt     <= 4'(MEM_LAT);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= misalign;
        if (!misalign && !wren) o_ld_data <= ld_val;
      end
      if (io_wr) begin
        case (addr[31:12])
          PG_LEDR: for (int b = 0; b < 4; b++) if (be[b]) o_io_ledr[8*b +: 8] <= be_data[8*b +: 8];
          PG_LEDG: for (int b = 0; b < 4; b++) if (be[b]) o_io_ledg[8*b +: 8] <= be_data[8*b +: 8];
          PG_LCD:  for (int b = 0; b < 4; b++) if (be[b]) o_io_lcd[8*b +: 8] <= be_data[8*b +: 8];
          PG_HEXLO: for (int k = 0; k < 4; k++) if (be[k] && (k < N_HEX)) hex[k] <= be_data[8*k +: 7];
          PG_HEXHI: for (int k = 0; k < 4; k++) if (be[k] && (k + 4 < N_HEX)) hex[k+4] <= be_data[8*k +: 7];
          default: ;
        endcase
      end
    end
  end

  // DMEM has no reset; the reset gate keeps a request sampled during reset from committing.
  always_ff @(posedge i_clk) begin
    if (mem_wr && i_reset) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr[DMEM_AW+1:2]][8*b +: 8] <= be_data[8*b +: 8];
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) o_io_hex[k] = hex[k];
  end

  assign o_lsu_busy = (state != S_IDLE);
  assign o_lsu_done = (state == S_DONE);
  assign o_lsu_err  = err_q;

endmodule
